// File: rtl/pan_digit_collector.sv
// Collects a BCD digit stream over valid/ready into a right-justified 19-digit PAN,
// enforcing length limits, digit legality and an inter-digit timeout.
module pan_digit_collector #(
  parameter int unsigned MIN_LEN        = 12,
  parameter int unsigned MAX_LEN        = 19,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_digit_i,
  input  logic        in_last_i,
  input  logic        pan_ack_i,
  output logic        pan_ready_o,
  output logic [75:0] pan_bcd_o,
  output logic [4:0]  len_final_o,
  output logic        pan_err_o,
  output logic [2:0]  err_code_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CntW-1:0] CntLast =
    (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] MinLen = 5'(MIN_LEN);
  localparam logic [4:0] MaxLen = 5'(MAX_LEN);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StCollect, StDone, StError} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [75:0]     pan_q;
  logic [4:0]      len_q;
  logic            pan_ready_q;
  logic            pan_err_q;
  logic [2:0]      err_code_q;
  logic            busy_q;

  logic        accept;
  logic [4:0]  new_len;
  logic [75:0] base_pan;
  logic [75:0] new_pan;
  logic        timeout_hit;
  logic [2:0]  err_d;

  always_comb begin
    in_ready_o = (state_q == StIdle) || (state_q == StCollect);
    accept     = in_valid_i && in_ready_o;
    // A fresh PAN starts from an empty word regardless of what DONE left behind.
    new_len    = (state_q == StIdle) ? 5'd1 : len_q + 5'd1;
    base_pan   = (state_q == StIdle) ? '0 : pan_q;
    new_pan    = {base_pan[71:0], in_digit_i};
    timeout_hit = TimeoutEn && (state_q == StCollect) && !accept && (cnt_q == CntLast);
    err_d = 3'd0;
    if (accept) begin
      if (in_digit_i > 4'd9) begin
        err_d = 3'd1;
      end else if (new_len > MaxLen) begin
        err_d = 3'd2;
      end else if (in_last_i && (new_len < MinLen)) begin
        err_d = 3'd3;
      end
    end else if (timeout_hit) begin
      err_d = 3'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pan_q       <= '0;
      len_q       <= '0;
      pan_ready_q <= 1'b0;
      pan_err_q   <= 1'b0;
      err_code_q  <= 3'd0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          if (err_d != 3'd0) begin
            state_q    <= StError;
            pan_err_q  <= 1'b1;
            err_code_q <= err_d;
            pan_q      <= '0;
            len_q      <= '0;
            busy_q     <= 1'b0;
          end else if (accept) begin
            pan_q <= new_pan;
            len_q <= new_len;
            cnt_q <= '0;
            if (in_last_i) begin
              state_q     <= StDone;
              pan_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q <= StCollect;
              busy_q  <= 1'b1;
            end
          end else if (state_q == StCollect) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (pan_ack_i) begin
            state_q     <= StIdle;
            pan_ready_q <= 1'b0;
          end
        end
        StError: begin
          if (pan_ack_i) begin
            state_q    <= StIdle;
            pan_err_q  <= 1'b0;
            err_code_q <= 3'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pan_ready_o = pan_ready_q;
  assign pan_bcd_o   = pan_q;
  assign len_final_o = len_q;
  assign pan_err_o   = pan_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pan_digit_collector.sv
// Self-checking bench for pan_digit_collector: vector table, directed corner sequences
// and randomized traffic against a digit-queue reference model.
module tb_pan_digit_collector;

  localparam int MinL = 12;
  localparam int MaxL = 19;
  localparam int To   = 8;

  localparam int MIdle = 0, MCol = 1, MDone = 2, MErr = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_digit = 4'd0;
  logic        in_last = 1'b0;
  logic        pan_ack = 1'b0;
  logic        pan_ready;
  logic [75:0] pan_bcd;
  logic [4:0]  len_final;
  logic        pan_err;
  logic [2:0]  err_code;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model: spec-level mode, the digits collected so far and an idle count.
  int          m_mode = MIdle;
  int          mq[$];
  logic [75:0] m_pan = '0;
  int          m_len = 0;
  int          m_code = 0;
  int          m_idle = 0;

  pan_digit_collector #(
    .MIN_LEN       (MinL),
    .MAX_LEN       (MaxL),
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_digit_i (in_digit),
    .in_last_i  (in_last),
    .pan_ack_i  (pan_ack),
    .pan_ready_o(pan_ready),
    .pan_bcd_o  (pan_bcd),
    .len_final_o(len_final),
    .pan_err_o  (pan_err),
    .err_code_o (err_code),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [75:0] pan_of();
    logic [75:0] p = '0;
    for (int i = 0; i < mq.size(); i++) begin
      p = p | (76'(mq[i]) << (4 * (mq.size() - 1 - i)));
    end
    return p;
  endfunction

  task automatic model_err(input int code);
    m_mode = MErr;
    m_code = code;
    mq.delete();
    m_pan = '0;
    m_len = 0;
  endtask

  task automatic model_update(input bit r, input bit v, input logic [3:0] d, input bit l,
                              input bit a);
    int n;
    int code;
    if (r) begin
      m_mode = MIdle;
      mq.delete();
      m_pan = '0;
      m_len = 0;
      m_code = 0;
      m_idle = 0;
    end else if (m_mode == MIdle || m_mode == MCol) begin
      if (v) begin
        n = (m_mode == MIdle) ? 1 : mq.size() + 1;
        code = (d > 9) ? 1 : (n > MaxL) ? 2 : (l && n < MinL) ? 3 : 0;
        if (code != 0) begin
          model_err(code);
        end else begin
          if (m_mode == MIdle) mq.delete();
          mq.push_back(int'(d));
          m_pan = pan_of();
          m_len = mq.size();
          m_idle = 0;
          m_mode = l ? MDone : MCol;
        end
      end else if (m_mode == MCol) begin
        m_idle++;
        if (m_idle == To) model_err(4);
      end
    end else if (a) begin
      m_mode = MIdle;
      m_code = 0;
    end
  endtask

  task automatic drive(input bit r, input bit v, input logic [3:0] d, input bit l,
                       input bit a);
    rst = r;
    in_valid = v;
    in_digit = d;
    in_last = l;
    pan_ack = a;
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] d, input bit l,
                      input bit a);
    drive(r, v, d, l, a);
    model_update(r, v, d, l, a);
    @(posedge clk);
    #1;
    chk("in_ready", 76'(in_ready), 76'(m_mode == MIdle || m_mode == MCol));
    chk("pan_ready", 76'(pan_ready), 76'(m_mode == MDone));
    chk("pan_err", 76'(pan_err), 76'(m_mode == MErr));
    chk("err_code", 76'(err_code), 76'((m_mode == MErr) ? m_code : 0));
    chk("busy", 76'(busy), 76'(m_mode == MCol));
    chk("len_final", 76'(len_final), 76'(m_len));
    chk("pan_bcd", pan_bcd, m_pan);
  endtask

  task automatic feed(input int n, input logic [3:0] d, input bit last_on_final);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, d, last_on_final && (i == n - 1), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          r, v;
    logic [3:0]  d;
    bit          l, a;
    bit          e_inr, e_prdy, e_err;
    logic [2:0]  e_code;
    logic [4:0]  e_len;
    bit          e_busy;
    logic [75:0] e_pan;
  } vec_t;

  vec_t tv[11];
  int   pa[16];

  initial begin
    tv[0]  = '{1, 0, 4'd0, 0, 0, 1, 0, 0, 3'd0, 5'd0, 0, 76'h0};
    tv[1]  = '{0, 1, 4'd5, 0, 0, 1, 0, 0, 3'd0, 5'd1, 1, 76'h5};
    tv[2]  = '{0, 1, 4'd3, 0, 0, 1, 0, 0, 3'd0, 5'd2, 1, 76'h53};
    tv[3]  = '{0, 0, 4'd0, 0, 0, 1, 0, 0, 3'd0, 5'd2, 1, 76'h53};
    tv[4]  = '{0, 1, 4'hA, 0, 0, 0, 0, 1, 3'd1, 5'd0, 0, 76'h0};
    tv[5]  = '{0, 1, 4'd2, 0, 1, 1, 0, 0, 3'd0, 5'd0, 0, 76'h0};
    tv[6]  = '{0, 1, 4'd7, 1, 0, 0, 0, 1, 3'd3, 5'd0, 0, 76'h0};
    tv[7]  = '{0, 0, 4'd0, 0, 1, 1, 0, 0, 3'd0, 5'd0, 0, 76'h0};
    tv[8]  = '{0, 0, 4'd0, 0, 1, 1, 0, 0, 3'd0, 5'd0, 0, 76'h0};
    tv[9]  = '{1, 1, 4'd1, 0, 0, 1, 0, 0, 3'd0, 5'd0, 0, 76'h0};
    tv[10] = '{0, 1, 4'd9, 0, 0, 1, 0, 0, 3'd0, 5'd1, 1, 76'h9};
    pa = '{4, 5, 3, 9, 1, 4, 8, 8, 0, 3, 4, 3, 6, 4, 6, 7};

    for (int i = 0; i < 11; i++) begin
      drive(tv[i].r, tv[i].v, tv[i].d, tv[i].l, tv[i].a);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          {in_ready, pan_ready, pan_err, err_code, len_final, busy, pan_bcd[59:0]},
          {tv[i].e_inr, tv[i].e_prdy, tv[i].e_err, tv[i].e_code, tv[i].e_len, tv[i].e_busy,
           tv[i].e_pan[59:0]});
    end

    // 16-digit PAN, held until ack.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(pa[i]), i == 15, 1'b0);
    chk("pan16", pan_bcd, 76'h0004539148803436467);
    chk("len16", 76'(len_final), 76'd16);
    chk("rdy16", 76'(pan_ready), 76'd1);
    idle(3);
    chk("hold16", pan_bcd, 76'h0004539148803436467);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("ack16", 76'(pan_ready), 76'd0);

    // Max length accepted; one more digit is too long.
    feed(19, 4'd9, 1'b1);
    chk("pan19", pan_bcd, 76'h9999999999999999999);
    chk("len19", 76'(len_final), 76'd19);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    feed(19, 4'd9, 1'b0);
    chk("busy19", 76'(busy), 76'd1);
    feed(1, 4'd9, 1'b0);
    chk("code_long", 76'(err_code), 76'd2);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Too short, then minimum length.
    feed(11, 4'd2, 1'b1);
    chk("code_short", 76'(err_code), 76'd3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    feed(12, 4'd3, 1'b1);
    chk("len12", 76'(len_final), 76'd12);
    chk("rdy12", 76'(pan_ready), 76'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Timeout fires on idle cycle 8; a digit on that cycle prevents it.
    feed(3, 4'd1, 1'b0);
    idle(7);
    chk("no_to_yet", 76'(pan_err), 76'd0);
    idle(1);
    chk("code_to", 76'(err_code), 76'd4);
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    feed(3, 4'd1, 1'b0);
    idle(7);
    feed(1, 4'd6, 1'b0);
    chk("to_saved", 76'(pan_err), 76'd0);
    chk("to_len", 76'(len_final), 76'd4);

    // Reset mid-collect, then a clean PAN; valid alongside ack in DONE is not taken.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    feed(7, 4'd5, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    chk("rst_len", 76'(len_final), 76'd0);
    chk("rst_busy", 76'(busy), 76'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(pa[i]), i == 15, 1'b0);
    chk("pan16b", pan_bcd, 76'h0004539148803436467);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
    chk("ack_nodig", pan_bcd, 76'h0004539148803436467);
    step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    chk("first_dig", pan_bcd, 76'h8);
    chk("first_len", 76'(len_final), 76'd1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit r, v, l, a;
      logic [3:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = (c % 150 < 12) ? 1'b0 : ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      l = (m_mode == MCol && mq.size() >= 10) ? ($urandom_range(0, 3) == 0)
                                              : ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 3) == 0);
      step(r, v, d, l, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
